alu_result_packer: RTL and testbench

Downstream consumer of the ALU shift unit's result/flag pair. Captures every cycle's `res_in` while `res_valid` is high into a small word FIFO, then serializes each word LSB-byte-first onto a byte-wide valid/ready stream feeding the system controller / UART TX path. The shift unit has no backpressure, so this block absorbs bursts and reports any loss through a sticky overflow flag.

---
 rtl/alu_result_packer_if.sv | 36 +++
 rtl/alu_result_packer.sv | 162 ++++++++++++++++
 tb/tb_alu_result_packer.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_result_packer_if.sv
// ============================================================================
//  Module   : alu_result_packer_if
//  Purpose  : Bundles the result-word input, byte stream output and status
//             signals of the ALU result packer.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface alu_result_packer_if #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 4
);
  logic [DATA_WIDTH-1:0]         res_in;
  logic                          res_valid;
  logic [7:0]                    byte_out;
  logic                          byte_valid;
  logic                          byte_ready;
  logic [$clog2(FIFO_DEPTH):0]   fifo_level;
  logic                          busy;
  logic                          overflow;
  logic                          clr_ovf;

  // Producer/consumer side (shift unit, byte sink, controller)
  modport master (
    output res_in, res_valid, byte_ready, clr_ovf,
    input  byte_out, byte_valid, fifo_level, busy, overflow
  );

  // Packer side
  modport slave (
    input  res_in, res_valid, byte_ready, clr_ovf,
    output byte_out, byte_valid, fifo_level, busy, overflow
  );
endinterface

`default_nettype wire

// File: rtl/alu_result_packer.sv
// ============================================================================
//  Module   : alu_result_packer
//  Purpose  : Buffers ALU result words in a small FIFO and serializes them
//             LSB-byte-first onto a valid/ready byte stream. Words arriving
//             while the FIFO is full are dropped and flagged (sticky).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_result_packer #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  wire logic            clk,
  input  wire logic            rst,
  alu_result_packer_if.slave   bus
);

  localparam int BYTES  = DATA_WIDTH / 8;
  localparam int ADDR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W  = ADDR_W + 1;
  localparam int IDX_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IDX_W-1:0] c_last_idx  = IDX_W'(BYTES - 1);
  localparam logic [LVL_W-1:0] c_full_lvl  = LVL_W'(FIFO_DEPTH);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  state_t                state_q,      state_d;
  logic [ADDR_W-1:0]     wr_ptr_q,     wr_ptr_d;
  logic [ADDR_W-1:0]     rd_ptr_q,     rd_ptr_d;
  logic [LVL_W-1:0]      level_q,      level_d;
  logic [DATA_WIDTH-1:0] word_q,       word_d;
  logic [IDX_W-1:0]      idx_q,        idx_d;
  logic [7:0]            byte_out_q,   byte_out_d;
  logic                  byte_valid_q, byte_valid_d;
  logic                  busy_q,       busy_d;
  logic                  overflow_q,   overflow_d;

  logic                  w_pop;
  logic                  w_wr_en;
  logic                  w_drop;
  logic                  w_full;
  logic                  w_hs;
  logic [DATA_WIDTH-1:0] w_head;
  logic [DATA_WIDTH-1:0] w_shift;

  // Next-state logic: serializer FSM, FIFO bookkeeping and status flags
  always_comb begin
    w_full  = (level_q == c_full_lvl);
    w_hs    = byte_valid_q & bus.byte_ready;
    w_head  = mem_q[rd_ptr_q];
    w_shift = word_q >> 8;

    state_d      = state_q;
    word_d       = word_q;
    idx_d        = idx_q;
    byte_out_d   = byte_out_q;
    byte_valid_d = byte_valid_q;
    w_pop        = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Only stored words are visible here, so a word written this edge
        // cannot fall through to the serializer until the next edge.
        if (level_q != '0) begin
          w_pop        = 1'b1;
          word_d       = w_head;
          byte_out_d   = w_head[7:0];
          idx_d        = '0;
          byte_valid_d = 1'b1;
          state_d      = S_SEND;
        end
      end
      S_SEND: begin
        if (w_hs) begin
          if (idx_q != c_last_idx) begin
            word_d     = w_shift;
            byte_out_d = w_shift[7:0];
            idx_d      = idx_q + IDX_W'(1);
          end else if (level_q != '0) begin
            // Chain straight into the next word without a bubble cycle
            w_pop      = 1'b1;
            word_d     = w_head;
            byte_out_d = w_head[7:0];
            idx_d      = '0;
          end else begin
            byte_valid_d = 1'b0;
            idx_d        = '0;
            state_d      = S_IDLE;
          end
        end
      end
      default: begin
        state_d      = S_IDLE;
        byte_valid_d = 1'b0;
      end
    endcase

    // A full FIFO still accepts a word when a pop frees a slot at the same edge
    w_wr_en  = bus.res_valid & (~w_full | w_pop);
    w_drop   = bus.res_valid & w_full & ~w_pop;

    wr_ptr_d = w_wr_en ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
    rd_ptr_d = w_pop   ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
    level_d  = level_q + LVL_W'(w_wr_en) - LVL_W'(w_pop);

    // A drop coinciding with a clear must remain visible
    if (w_drop)           overflow_d = 1'b1;
    else if (bus.clr_ovf) overflow_d = 1'b0;
    else                  overflow_d = overflow_q;

    busy_d = byte_valid_d | (level_d != '0);
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      word_q       <= '0;
      idx_q        <= '0;
      byte_out_q   <= '0;
      byte_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      word_q       <= word_d;
      idx_q        <= idx_d;
      byte_out_q   <= byte_out_d;
      byte_valid_q <= byte_valid_d;
      busy_q       <= busy_d;
      overflow_q   <= overflow_d;
    end
  end

  // FIFO storage; contents are don't-care while the pointers say empty
  always_ff @(posedge clk) begin
    if (!rst && w_wr_en) begin
      mem_q[wr_ptr_q] <= bus.res_in;
    end
  end

  assign bus.byte_out   = byte_out_q;
  assign bus.byte_valid = byte_valid_q;
  assign bus.fifo_level = level_q;
  assign bus.busy       = busy_q;
  assign bus.overflow   = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_result_packer.sv
// ============================================================================
//  Module   : tb_alu_result_packer
//  Purpose  : Directed self-checking bench for alu_result_packer.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_result_packer;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;

  logic [7:0] got_q[$];
  int         got_cyc[$];
  logic [7:0] exp_q[$];

  alu_result_packer_if #(.DATA_WIDTH(16), .FIFO_DEPTH(4)) bus ();

  alu_result_packer #(.DATA_WIDTH(16), .FIFO_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every byte that completes a handshake at a rising edge
  always @(posedge clk) begin
    if (!rst && bus.byte_valid && bus.byte_ready) begin
      got_q.push_back(bus.byte_out);
      got_cyc.push_back(cyc);
    end
    cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.res_valid = 1'b0;
    bus.clr_ovf   = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w);
    bus.res_in    = w;
    bus.res_valid = 1'b1;
    tick();
    bus.res_valid = 1'b0;
  endtask

  task automatic drain(input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      tick();
      if (!bus.busy) break;
    end
  endtask

  task automatic compare_stream(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) check($sformatf("%s_byte%0d", tag, i), got_q[i], exp_q[i]);
    end
  endtask

  // Words {B0+k, A0+k}: LSB stream reads A0+k then B0+k
  function automatic logic [15:0] pat(input int k);
    return {8'hB0 + 8'(k), 8'hA0 + 8'(k)};
  endfunction

  initial begin
    rst = 1'b1;
    bus.res_in     = '0;
    bus.res_valid  = 1'b0;
    bus.byte_ready = 1'b0;
    bus.clr_ovf    = 1'b0;

    // ---- reset state
    do_reset();
    check("rst_valid", bus.byte_valid, 1'b0);
    check("rst_byte",  bus.byte_out,   8'h00);
    check("rst_level", bus.fifo_level, 3'd0);
    check("rst_busy",  bus.busy,       1'b0);
    check("rst_ovf",   bus.overflow,   1'b0);

    // ---- single word A55A
    bus.byte_ready = 1'b1;
    send_word(16'hA55A);
    check("single_k_valid", bus.byte_valid, 1'b0);
    check("single_k_level", bus.fifo_level, 3'd1);
    tick();
    check("single_b0_valid", bus.byte_valid, 1'b1);
    check("single_b0",       bus.byte_out,   8'h5A);
    tick();
    check("single_b1_valid", bus.byte_valid, 1'b1);
    check("single_b1",       bus.byte_out,   8'hA5);
    tick();
    check("single_end_valid", bus.byte_valid, 1'b0);
    check("single_end_busy",  bus.busy,       1'b0);

    // ---- backpressure on 1234
    bus.byte_ready = 1'b0;
    send_word(16'h1234);
    tick();
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp_hold_valid%0d", i), bus.byte_valid, 1'b1);
      check($sformatf("bp_hold_byte%0d", i),  bus.byte_out,   8'h34);
      tick();
    end
    got_q.delete();
    bus.byte_ready = 1'b1;
    drain(10);
    exp_q = '{8'h34, 8'h12};
    compare_stream("bp");
    check("bp_busy", bus.busy, 1'b0);

    // ---- back-to-back burst 0001..0004
    got_q.delete();
    got_cyc.delete();
    bus.byte_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      bus.res_in    = 16'(i);
      bus.res_valid = 1'b1;
      tick();
    end
    bus.res_valid = 1'b0;
    for (int i = 0; i < 20 && got_q.size() < 8; i++) tick();
    exp_q = '{8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00, 8'h04, 8'h00};
    compare_stream("burst");
    if (got_cyc.size() == 8) check("burst_no_gap", got_cyc[7] - got_cyc[0], 7);
    else                     check("burst_no_gap", got_cyc.size(), 8);
    drain(10);

    // ---- overflow: 6 words into a stalled sink
    do_reset();
    bus.byte_ready = 1'b0;
    for (int k = 0; k < 5; k++) send_word(pat(k));
    check("ovf_before_drop", bus.overflow,   1'b0);
    check("ovf_level_full",  bus.fifo_level, 3'd4);
    send_word(pat(5));
    check("ovf_set",         bus.overflow,   1'b1);
    check("ovf_level_kept",  bus.fifo_level, 3'd4);
    // drop together with clear: the drop wins
    bus.res_in    = 16'hDEAD;
    bus.res_valid = 1'b1;
    bus.clr_ovf   = 1'b1;
    tick();
    bus.res_valid = 1'b0;
    check("ovf_drop_beats_clr", bus.overflow, 1'b1);
    tick();
    bus.clr_ovf = 1'b0;
    check("ovf_cleared", bus.overflow, 1'b0);
    got_q.delete();
    bus.byte_ready = 1'b1;
    drain(30);
    exp_q.delete();
    for (int k = 0; k < 5; k++) begin
      exp_q.push_back(8'hA0 + 8'(k));
      exp_q.push_back(8'hB0 + 8'(k));
    end
    compare_stream("ovf_drain");

    // ---- full FIFO with write at the pop edge
    do_reset();
    bus.byte_ready = 1'b0;
    for (int k = 0; k < 5; k++) send_word(pat(k));
    got_q.delete();
    bus.byte_ready = 1'b1;
    tick();                               // byte 0 of word 0 accepted
    bus.res_in    = 16'hEE77;
    bus.res_valid = 1'b1;
    tick();                               // last byte accepted, pop + write
    bus.res_valid = 1'b0;
    check("fullpop_level", bus.fifo_level, 3'd4);
    check("fullpop_ovf",   bus.overflow,   1'b0);
    drain(30);
    exp_q.delete();
    for (int k = 0; k < 5; k++) begin
      exp_q.push_back(8'hA0 + 8'(k));
      exp_q.push_back(8'hB0 + 8'(k));
    end
    exp_q.push_back(8'h77);
    exp_q.push_back(8'hEE);
    compare_stream("fullpop");

    // ---- reset in the middle of BEEF with two words queued
    do_reset();
    bus.byte_ready = 1'b0;
    send_word(16'hBEEF);
    send_word(16'h1111);
    send_word(16'h2222);
    check("midrst_level", bus.fifo_level, 3'd2);
    got_q.delete();
    bus.byte_ready = 1'b1;
    tick();                               // EF accepted, BE now presented
    check("midrst_pre_byte", bus.byte_out, 8'hBE);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_valid", bus.byte_valid, 1'b0);
    check("midrst_byte",  bus.byte_out,   8'h00);
    check("midrst_lvl",   bus.fifo_level, 3'd0);
    check("midrst_busy",  bus.busy,       1'b0);
    check("midrst_ovf",   bus.overflow,   1'b0);
    for (int i = 0; i < 10; i++) tick();
    exp_q = '{8'hEF};
    compare_stream("midrst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
